// File: rtl/fpadd_result_queue.sv
// fpadd_result_queue: DEPTH-entry result FIFO behind fpadd, with NaN-boxing and sticky flags.
// Optional build macro FPADD_RQ_DENORM_TRAP_EN: stored denorm also raises UF on output and into sticky.
`default_nettype none

module fpadd_result_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_result,
  input  logic [4:0]    in_flags,
  input  logic          in_denorm,
  input  logic          in_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_result,
  output logic [4:0]    out_flags,
  output logic          out_denorm,
  output logic [4:0]    sticky_flags,
  input  logic          sticky_clr,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [63:0]   r_res [DEPTH];
  logic [4:0]    r_flg [DEPTH];
  logic          r_dn  [DEPTH];
  logic          r_p   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [4:0]    r_sticky;

  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_head_res;
  logic [4:0]    w_head_flags;

  // Handshake depends only on registered count; a full queue refuses even when popping.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_head_res = r_res[r_rd_ptr];

`ifdef FPADD_RQ_DENORM_TRAP_EN
  assign w_head_flags = r_flg[r_rd_ptr] | {3'b000, r_dn[r_rd_ptr], 1'b0};
`else
  assign w_head_flags = r_flg[r_rd_ptr];
`endif

  assign out_result   = r_p[r_rd_ptr] ? {32'hFFFF_FFFF, w_head_res[63:32]} : w_head_res;
  assign out_flags    = w_head_flags;
  assign out_denorm   = r_dn[r_rd_ptr];
  assign sticky_flags = r_sticky;
  assign count        = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
        r_flg[i] <= '0;
        r_dn[i]  <= 1'b0;
        r_p[i]   <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sticky <= '0;
    end else begin
      if (w_push) begin
        r_res[r_wr_ptr] <= in_result;
        r_flg[r_wr_ptr] <= in_flags;
        r_dn[r_wr_ptr]  <= in_denorm;
        r_p[r_wr_ptr]   <= in_p;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      // A clear in the same cycle as a pop still keeps that pop's flags.
      r_sticky <= (sticky_clr ? 5'b0 : r_sticky) | (w_pop ? w_head_flags : 5'b0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpadd_result_queue.sv
// tb_fpadd_result_queue: directed self-checking bench for fpadd_result_queue (DEPTH = 4).
`default_nettype none

module tb_fpadd_result_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_result;
  logic [4:0]    in_flags;
  logic          in_denorm;
  logic          in_p;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_result;
  logic [4:0]    out_flags;
  logic          out_denorm;
  logic [4:0]    sticky_flags;
  logic          sticky_clr;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_dn_flags;

  fpadd_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_denorm(in_denorm), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_denorm(out_denorm),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_denorm = 1'b0;
    in_p = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);

    // Single-precision push, NaN-boxed at the head next cycle
    in_valid = 1'b1; in_result = 64'h40000000_00000000; in_p = 1'b1;
    tick();
    in_valid = 1'b0; in_p = 1'b0;
    chk("sp_out_valid", 64'(out_valid), 64'd1);
    chk("sp_out_result", out_result, 64'hFFFFFFFF_40000000);
    chk("sp_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sp_pop_count", 64'(count), 64'd0);
    chk("sp_pop_valid", 64'(out_valid), 64'd0);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 64'hA000_0000_0000_0000 + 64'(i);
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_result = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("full_reject_count", 64'(count), 64'd4);
    chk("full_head_stable", out_result, 64'hA000_0000_0000_0000);

    // Drain in FIFO order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_order", out_result, 64'hA000_0000_0000_0000 + 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Streaming 0..9 with consumer always ready; pointers wrap
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_result = 64'(k); in_p = 1'b0;
      tick();
      chk("stream_data", out_result, 64'(k));
      chk("stream_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Sticky accumulation and same-cycle clear
    in_valid = 1'b1; in_result = 64'h1; in_flags = 5'b00001; tick();
    in_result = 64'h2; in_flags = 5'b00100; tick();
    in_result = 64'h3; in_flags = 5'b10000; tick();
    in_valid = 1'b0; in_flags = 5'b0;
    chk("sticky_pre", 64'(sticky_flags), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("sticky_one", 64'(sticky_flags), 64'b00001);
    tick();
    chk("sticky_acc", 64'(sticky_flags), 64'b00101);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0; out_ready = 1'b0;
    chk("sticky_clr_pop", 64'(sticky_flags), 64'b10000);
    chk("sticky_count", 64'(count), 64'd0);

    // Denorm entry
`ifdef FPADD_RQ_DENORM_TRAP_EN
    exp_dn_flags = 5'b00011;
`else
    exp_dn_flags = 5'b00001;
`endif
    in_valid = 1'b1; in_result = 64'h5; in_flags = 5'b00001; in_denorm = 1'b1;
    tick();
    in_valid = 1'b0; in_flags = 5'b0; in_denorm = 1'b0;
    chk("dn_out_flags", 64'(out_flags), 64'(exp_dn_flags));
    chk("dn_out_denorm", 64'(out_denorm), 64'd1);
    out_ready = 1'b1; sticky_clr = 1'b1;
    tick();
    out_ready = 1'b0; sticky_clr = 1'b0;
    chk("dn_sticky", 64'(sticky_flags), 64'(exp_dn_flags));

    // Mid-stream reset with 3 queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = 64'h7777_0000_0000_0000 + 64'(i); in_p = 1'b1;
      in_flags = 5'b01000;
      tick();
    end
    in_valid = 1'b0; in_p = 1'b0; in_flags = 5'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", out_result, 64'd0);
    chk("mid_rst_flags", 64'(out_flags), 64'd0);
    chk("mid_rst_sticky", 64'(sticky_flags), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpadd_result_queue.md
# fpadd_result_queue

Registered result buffer directly downstream of `fpadd`: captures each `fpadd` result, its exception flags and its denormal indication. Buffers these in a DEPTH-entry FIFO behind a valid/ready handshake, so a stalled consumer (register file writeback) never drops a result. Single-precision results are NaN-boxed on output. Exception flags of retired results are OR-accumulated into a sticky register (fflags-style) that software can clear.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, $clog2(DEPTH+1), width of `count`

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  `fpadd` output is valid this cycle
- in_ready  out  1  queue can accept; equals (count != DEPTH)
- in_result  in  64  `fpadd` result; single precision occupies [63:32]
- in_flags  in  5  `fpadd` Flags, bit order {NV, DZ, OF, UF, NX} = [4:0]
- in_denorm  in  1  `fpadd` Denorm
- in_p  in  1  precision of this op, 1 = single (same meaning as `fpadd` P)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_result  out  64  head result, NaN-boxed if single
- out_flags  out  5  head flags
- out_denorm  out  1  head Denorm
- sticky_flags  out  5  accumulated flags of all popped entries
- sticky_clr  in  1  clear sticky register
- count  out  CW  occupied entries

## Operation
- Push: in_valid && in_ready. Entry stores {in_result, in_flags, in_denorm, in_p} at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments mod DEPTH.
- Output formatting (combinational from head entry):
  - p=1: out_result = {32'hFFFF_FFFF, stored[63:32]}
  - p=0: out_result = stored[63:0]
- Sticky update per cycle: base = sticky_clr ? 5'b0 : sticky_flags. Then sticky_flags <= base | (pop ? head_flags : 5'b0). A clear issued in the same cycle as a pop keeps that pop's flags.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count == DEPTH): in_ready = 0, including when a pop occurs in the same cycle (no full-bypass). in_valid while full is ignored; the upstream holds the result.
- Empty (count == 0): out_valid = 0. out_ready is ignored. There is no input-to-output bypass.
- Simultaneous push and pop at 0 < count < DEPTH: both proceed and count holds.
- Pointers wrap at DEPTH−1 → 0.

## Timing
- Latency: a result pushed in cycle N is at the head with out_valid = 1 in cycle N+1 at the earliest.
- Throughput: 1 entry per cycle in steady state with out_ready held high.
- in_ready and out_valid are derived from registered count only; there is no combinational path from in_valid or out_ready.
- Head data is stable while out_valid && !out_ready.
- Reset (any cycle, including mid-stream) sets the following next edge:
  - count = 0, pointers = 0, sticky_flags = 0
  - out_valid = 0, in_ready = 1
  - out_result, out_flags, out_denorm = 0 (head storage cleared)
  - In-flight entries are discarded.

## Configuration
- FPADD_RQ_DENORM_TRAP_EN defined:
  - An entry whose stored denorm = 1 also forces UF (bit 1) into out_flags and into the sticky accumulation.
  - The stored flags are unmodified; the forcing is applied on output.
- Not defined:
  - Denorm is carried through to out_denorm only and has no effect on flags.

## Test plan
- After reset, expect count = 0, in_ready = 1, out_valid = 0, sticky_flags = 0.
  - Push in_result = 64'h40000000_00000000, in_p = 1, in_flags = 0.
  - Next cycle: out_valid = 1, out_result = 64'hFFFFFFFF_40000000.
- Push 4 entries with out_ready = 0 (DEPTH = 4).
  - Expect count = 4 and in_ready = 0.
  - A fifth push with in_valid = 1 is not accepted.
  - Pop all 4: expect FIFO order, then out_valid = 0.
- Hold out_ready = 1 and push 10 entries back-to-back (values 0..9, p = 0).
  - Outputs appear in order, one per cycle.
  - count stays 1; pointers wrap with no loss.
- Pop entries with flags 5'b00001, then 5'b00100: expect sticky_flags = 5'b00101.
  - Assert sticky_clr in the same cycle as a pop of 5'b10000: expect sticky_flags = 5'b10000.
- Push an entry with in_denorm = 1, in_flags = 5'b00001 and pop it.
  - With FPADD_RQ_DENORM_TRAP_EN: out_flags = 5'b00011, sticky = 5'b00011.
  - Without it: out_flags = 5'b00001, out_denorm = 1.
- Assert reset for one cycle with 3 entries queued.
  - Next cycle: count = 0, out_valid = 0, out_result = 0, sticky_flags = 0.
